// File: rtl/comparator_1bit_pkg.sv
// Shared types for the registered 1-bit comparator: the one-hot result encoding
// and its decode into the three output flags.
package comparator_1bit_pkg;

  typedef logic [2:0] cmp_res_t;

  localparam cmp_res_t CMP_EQ   = 3'b001;
  localparam cmp_res_t CMP_LT   = 3'b010;
  localparam cmp_res_t CMP_GT   = 3'b100;
  localparam cmp_res_t CMP_NONE = 3'b000;

  typedef struct packed {
    logic eq;
    logic lt;
    logic gt;
  } cmp_flags_t;

  function automatic cmp_flags_t cmp_to_flags(input cmp_res_t res);
    cmp_flags_t flags;
    flags.eq = res[0];
    flags.lt = res[1];
    flags.gt = res[2];
    return flags;
  endfunction

endpackage

// File: rtl/comparator_1bit_if.sv
// Operand/result bundle for comparator_1bit. The counter and clear signals
// exist only when COMPARATOR_1BIT_STATS_EN is defined.
interface comparator_1bit_if #(
  parameter int CNT_W = 16
);

  logic in_valid;
  logic A;
  logic B;
  logic out_valid;
  logic A_eq_B;
  logic A_lt_B;
  logic A_gt_B;
`ifdef COMPARATOR_1BIT_STATS_EN
  logic             stats_clr;
  logic [CNT_W-1:0] eq_cnt;
  logic [CNT_W-1:0] lt_cnt;
  logic [CNT_W-1:0] gt_cnt;
`endif

  if (CNT_W < 2 || CNT_W > 32) begin : g_bad_cnt_w
    $error("comparator_1bit_if: CNT_W must be in 2..32");
  end

`ifdef COMPARATOR_1BIT_STATS_EN
  modport master (
    output in_valid, A, B, stats_clr,
    input  out_valid, A_eq_B, A_lt_B, A_gt_B, eq_cnt, lt_cnt, gt_cnt
  );
  modport slave (
    input  in_valid, A, B, stats_clr,
    output out_valid, A_eq_B, A_lt_B, A_gt_B, eq_cnt, lt_cnt, gt_cnt
  );
`else
  modport master (
    output in_valid, A, B,
    input  out_valid, A_eq_B, A_lt_B, A_gt_B
  );
  modport slave (
    input  in_valid, A, B,
    output out_valid, A_eq_B, A_lt_B, A_gt_B
  );
`endif

endinterface

// File: rtl/comparator_1bit_chk.sv
// Simulation-only checks for comparator_1bit: no unknown operands while
// sampling, and a one-hot result whenever out_valid is set.
module comparator_1bit_chk (
  input logic clk,
  input logic rst_n,
  input logic in_valid,
  input logic a,
  input logic b,
  input logic out_valid,
  input logic eq,
  input logic lt,
  input logic gt
);

  a_no_x_operands: assert property (
    @(posedge clk) disable iff (!rst_n) in_valid |-> !$isunknown({a, b})
  ) else $error("comparator_1bit: X/Z on A or B while in_valid");

  a_onehot_result: assert property (
    @(posedge clk) disable iff (!rst_n) out_valid |-> $onehot({eq, lt, gt})
  ) else $error("comparator_1bit: result flags not one-hot");

endmodule

// File: rtl/comparator_1bit_core.sv
// Purely combinational 1-bit magnitude compare producing a one-hot {gt, lt, eq}.
module comparator_1bit_core
  import comparator_1bit_pkg::*;
(
  input  logic     a,
  input  logic     b,
  output cmp_res_t res
);

  assign res = {a & ~b, ~a & b, ~(a ^ b)};

endmodule

// File: rtl/comparator_1bit.sv
// Registered 1-bit magnitude comparator with a sticky valid bit.
// Optional saturating result counters are enabled by COMPARATOR_1BIT_STATS_EN.
module comparator_1bit
  import comparator_1bit_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              rst_n,
  comparator_1bit_if.slave bus
);

  if (CNT_W < 2 || CNT_W > 32) begin : g_bad_cnt_w
    $error("comparator_1bit: CNT_W must be in 2..32");
  end

  cmp_res_t   core_res_s;
  cmp_res_t   res_d;
  cmp_res_t   res_q;
  logic       out_valid_d;
  logic       out_valid_q;
  cmp_flags_t flags_s;

  comparator_1bit_core u_core (
    .a   (bus.A),
    .b   (bus.B),
    .res (core_res_s)
  );

  // Load a new result on each accepted sample; otherwise hold, valid stays sticky.
  always_comb begin
    res_d       = res_q;
    out_valid_d = out_valid_q;
    if (bus.in_valid) begin
      res_d       = core_res_s;
      out_valid_d = 1'b1;
    end else begin
      res_d       = res_q;
      out_valid_d = out_valid_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q       <= CMP_NONE;
      out_valid_q <= 1'b0;
    end else begin
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign flags_s       = cmp_to_flags(res_q);
  assign bus.out_valid = out_valid_q;
  assign bus.A_eq_B    = flags_s.eq;
  assign bus.A_lt_B    = flags_s.lt;
  assign bus.A_gt_B    = flags_s.gt;

`ifdef COMPARATOR_1BIT_STATS_EN
  logic [CNT_W-1:0] eq_cnt_d;
  logic [CNT_W-1:0] eq_cnt_q;
  logic [CNT_W-1:0] lt_cnt_d;
  logic [CNT_W-1:0] lt_cnt_q;
  logic [CNT_W-1:0] gt_cnt_d;
  logic [CNT_W-1:0] gt_cnt_q;

  // Clear wins over increment; counting stops at all-ones.
  function automatic logic [CNT_W-1:0] cnt_next(
    input logic [CNT_W-1:0] cnt,
    input logic             hit,
    input logic             clr
  );
    logic [CNT_W-1:0] nxt;
    if (clr) begin
      nxt = '0;
    end else if (hit && (cnt != {CNT_W{1'b1}})) begin
      nxt = cnt + CNT_W'(1);
    end else begin
      nxt = cnt;
    end
    return nxt;
  endfunction

  // Next-state for the three result counters.
  always_comb begin
    eq_cnt_d = cnt_next(eq_cnt_q, bus.in_valid & core_res_s[0], bus.stats_clr);
    lt_cnt_d = cnt_next(lt_cnt_q, bus.in_valid & core_res_s[1], bus.stats_clr);
    gt_cnt_d = cnt_next(gt_cnt_q, bus.in_valid & core_res_s[2], bus.stats_clr);
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eq_cnt_q <= '0;
      lt_cnt_q <= '0;
      gt_cnt_q <= '0;
    end else begin
      eq_cnt_q <= eq_cnt_d;
      lt_cnt_q <= lt_cnt_d;
      gt_cnt_q <= gt_cnt_d;
    end
  end

  assign bus.eq_cnt = eq_cnt_q;
  assign bus.lt_cnt = lt_cnt_q;
  assign bus.gt_cnt = gt_cnt_q;
`endif

`ifndef SYNTHESIS
  comparator_1bit_chk u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .a         (bus.A),
    .b         (bus.B),
    .out_valid (out_valid_q),
    .eq        (flags_s.eq),
    .lt        (flags_s.lt),
    .gt        (flags_s.gt)
  );
`endif

endmodule

// File: tb/tb_comparator_1bit.sv
// Directed, table-driven bench for comparator_1bit plus hand-written sequences
// for hold, asynchronous reset and (when enabled) the saturating counters.
module tb_comparator_1bit;

`ifdef COMPARATOR_1BIT_STATS_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 16;
`endif

  typedef struct {
    logic iv;
    logic a;
    logic b;
    logic ev;
    logic eeq;
    logic elt;
    logic egt;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  vec_t vecs[10];

  comparator_1bit_if #(.CNT_W(CNT_W)) bus ();

  comparator_1bit #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_flags(input string name, input logic v, input logic eq,
                             input logic lt, input logic gt);
    check({name, ".out_valid"}, 32'(bus.out_valid), 32'(v));
    check({name, ".flags"}, 32'({bus.A_eq_B, bus.A_lt_B, bus.A_gt_B}), 32'({eq, lt, gt}));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic a, input logic b);
    bus.in_valid = iv;
    bus.A        = a;
    bus.B        = b;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
`ifdef COMPARATOR_1BIT_STATS_EN
    bus.stats_clr = 1'b0;
`endif

    //             iv    a     b     ev    eq    lt    gt
    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    // Reset held with random operands and in_valid toggling.
    for (int i = 0; i < 4; i++) begin
      drive(1'(($urandom & 32'd1)), 1'(($urandom & 32'd1)), 1'(($urandom & 32'd1)));
      tick();
      check_flags("reset_hold", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;

    // Vector table: each entry is applied, clocked once, then compared.
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].iv, vecs[i].a, vecs[i].b);
      tick();
      check_flags($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eeq, vecs[i].elt, vecs[i].egt);
    end

    // Hold: sample (1,0), then toggle operands with in_valid low.
    drive(1'b1, 1'b1, 1'b0);
    tick();
    check_flags("hold_load", 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'(i & 1), 1'((i >> 1) & 1));
      tick();
      check_flags($sformatf("hold%0d", i), 1'b1, 1'b0, 1'b0, 1'b1);
    end

    // Mid-stream reset between edges clears outputs without a clock edge.
    drive(1'b1, 1'b0, 1'b1);
    tick();
    check_flags("pre_rst", 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check_flags("async_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b1);
    tick();
    check_flags("post_rst", 1'b1, 1'b1, 1'b0, 1'b0);

`ifdef COMPARATOR_1BIT_STATS_EN
    // Fresh reset so counters start from zero.
    drive(1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    check("cnt_rst.eq", 32'(bus.eq_cnt), 32'd0);
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      tick();
      check($sformatf("sat%0d.eq", i), 32'(bus.eq_cnt), (i > 3) ? 32'd3 : 32'(i));
      check($sformatf("sat%0d.lt", i), 32'(bus.lt_cnt), 32'd0);
      check($sformatf("sat%0d.gt", i), 32'(bus.gt_cnt), 32'd0);
    end
    drive(1'b1, 1'b1, 1'b0);
    tick();
    check("gt_inc", 32'(bus.gt_cnt), 32'd1);
    drive(1'b1, 1'b0, 1'b0);
    bus.stats_clr = 1'b1;
    tick();
    bus.stats_clr = 1'b0;
    check("clr.eq", 32'(bus.eq_cnt), 32'd0);
    check("clr.gt", 32'(bus.gt_cnt), 32'd0);
    check_flags("clr_flags", 1'b1, 1'b1, 1'b0, 1'b0);
`endif

    drive(1'b0, 1'b0, 1'b0);
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
